// File: rtl/arch_maptable_pkg.sv
// Shared rename-path types: retire lanes, committed map entries and freelist returns.
// Width macros are global so every file in the slice sizes these structs the same way.
`ifndef ARCH_MAPTABLE_PKG_SV
`define ARCH_MAPTABLE_PKG_SV

`define RT_NUM         2
`define MT_ENTRY       32
`define TAG_IDX_WIDTH  6
`define ARCH_IDX_WIDTH 5

package arch_maptable_pkg;

    typedef struct packed {
        logic                         wr_en;
        logic [`ARCH_IDX_WIDTH-1:0]   arch_reg;
        logic [`TAG_IDX_WIDTH-1:0]    phy_tag;
    } ROB_AMT;

    typedef struct packed {
        logic [`TAG_IDX_WIDTH-1:0]    amt_tag;
    } AMT_ENTRY;

    typedef struct packed {
        logic                         valid;
        logic [`TAG_IDX_WIDTH-1:0]    tag;
    } AMT_FL;

endpackage

`endif

// File: rtl/amt_bypass.sv
// Applies retire lanes in age order to the committed map, yielding the
// overlaid map and the tag each lane displaces.
module amt_bypass
    import arch_maptable_pkg::*;
#(
    parameter int C_RT_NUM         = `RT_NUM,
    parameter int C_MT_ENTRY       = `MT_ENTRY,
    parameter int C_TAG_IDX_WIDTH  = `TAG_IDX_WIDTH,
    parameter int C_ARCH_IDX_WIDTH = $clog2(C_MT_ENTRY)
) (
    input  AMT_ENTRY                   amt_i     [C_MT_ENTRY],
    input  ROB_AMT                     rob_amt_i [C_RT_NUM],
    output AMT_ENTRY                   amt_o     [C_MT_ENTRY],
    output logic [C_TAG_IDX_WIDTH-1:0] old_tag_o [C_RT_NUM]
);

    AMT_ENTRY                    ovl [C_MT_ENTRY];
    logic [C_ARCH_IDX_WIDTH-1:0] arch;

    // Each lane reads the map as already updated by older lanes, which is
    // exactly the intra-bundle bypass; later lanes overwrite earlier ones.
    always_comb begin
        ovl  = amt_i;
        arch = '0;
        for (int r = 0; r < C_RT_NUM; r++) begin
            arch         = rob_amt_i[r].arch_reg;
            old_tag_o[r] = ovl[arch].amt_tag;
            if (rob_amt_i[r].wr_en && arch != '0) begin
                ovl[arch].amt_tag = rob_amt_i[r].phy_tag;
            end
        end
    end

    assign amt_o = ovl;

endmodule

// File: rtl/arch_maptable.sv
// Architectural map table: committed arch->phy mapping updated by retire
// lanes, with registered release of displaced tags to the freelist.
module arch_maptable
    import arch_maptable_pkg::*;
#(
    parameter int C_RT_NUM         = `RT_NUM,
    parameter int C_MT_ENTRY       = `MT_ENTRY,
    parameter int C_TAG_IDX_WIDTH  = `TAG_IDX_WIDTH,
    parameter int C_ARCH_IDX_WIDTH = $clog2(C_MT_ENTRY)
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     rollback_i,
    input  ROB_AMT   rob_amt_i [C_RT_NUM],
    output AMT_ENTRY amt_o     [C_MT_ENTRY],
    output AMT_FL    amt_fl_o  [C_RT_NUM]
);

    AMT_ENTRY                   amt_q   [C_MT_ENTRY];
    AMT_ENTRY                   amt_d   [C_MT_ENTRY];
    AMT_FL                      fl_q    [C_RT_NUM];
    AMT_FL                      fl_d    [C_RT_NUM];
    logic [C_TAG_IDX_WIDTH-1:0] old_tag [C_RT_NUM];

    // Committed state is never squashed, so rollback has no effect here.
    logic unused_rollback;
    assign unused_rollback = rollback_i;

    amt_bypass #(
        .C_RT_NUM         (C_RT_NUM),
        .C_MT_ENTRY       (C_MT_ENTRY),
        .C_TAG_IDX_WIDTH  (C_TAG_IDX_WIDTH),
        .C_ARCH_IDX_WIDTH (C_ARCH_IDX_WIDTH)
    ) u_bypass (
        .amt_i     (amt_q),
        .rob_amt_i (rob_amt_i),
        .amt_o     (amt_d),
        .old_tag_o (old_tag)
    );

    // Retiring to x0 frees the incoming tag instead of a displaced one.
    always_comb begin
        for (int r = 0; r < C_RT_NUM; r++) begin
            fl_d[r] = '0;
            if (rob_amt_i[r].wr_en) begin
                fl_d[r].valid = 1'b1;
                fl_d[r].tag   = (rob_amt_i[r].arch_reg == '0) ?
                                rob_amt_i[r].phy_tag : old_tag[r];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < C_MT_ENTRY; i++) begin
                amt_q[i].amt_tag <= C_TAG_IDX_WIDTH'(i);
            end
            for (int r = 0; r < C_RT_NUM; r++) begin
                fl_q[r] <= '0;
            end
        end else begin
            amt_q <= amt_d;
            fl_q  <= fl_d;
        end
    end

    assign amt_o    = amt_d;
    assign amt_fl_o = fl_q;

endmodule

// File: doc/arch_maptable.md
Name: arch_maptable

Overview:
- Architectural map table (AMT) at the retire end of the rename path.
- Holds the committed arch-reg → phy-tag mapping, updated by ROB retire lanes.
- Drives amt_o, which the speculative map table copies on rollback_i.
- Returns each overwritten committed tag to the freelist, one cycle after retire.

Parameters:
C_RT_NUM, `RT_NUM (2), retire lanes per cycle
C_MT_ENTRY, `MT_ENTRY (32), architectural registers
C_TAG_IDX_WIDTH, `TAG_IDX_WIDTH (6), physical tag width
C_ARCH_IDX_WIDTH, $clog2(C_MT_ENTRY), arch reg index width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
rollback_i  in  1  squash pulse (same signal the map table sees)
rob_amt_i  in  C_RT_NUM x ROB_AMT  per lane {wr_en, arch_reg[C_ARCH_IDX_WIDTH], phy_tag[C_TAG_IDX_WIDTH]}, lane 0 oldest
amt_o  out  C_MT_ENTRY x AMT_ENTRY  {amt_tag}; committed map including same-cycle retires
amt_fl_o  out  C_RT_NUM x AMT_FL  per lane {valid, tag}; released tag to freelist

Behaviour:
- Reset (async, immediate): entry[i].amt_tag = i for every i; amt_fl_o all valid=0, tag=0. Free tags C_MT_ENTRY and up are owned by the freelist.
- Retire write, posedge: for each lane r with wr_en and arch_reg != 0, entry[arch_reg] <= phy_tag.
  - Lanes are applied in order, so the highest-numbered lane wins on an arch_reg collision.
- arch_reg == 0 with wr_en:
  - No AMT write.
  - phy_tag itself is released: amt_fl_o[r].valid=1, tag=phy_tag.
- Released tag, normal case: for lane r with wr_en, arch_reg != 0, the old tag is the committed tag being overwritten.
  - Intra-bundle bypass: if a lower lane q<r writes the same arch_reg this cycle, old = the phy_tag of the highest such q.
  - Otherwise old = entry[arch_reg].amt_tag.
- amt_fl_o is registered: lane r valid/tag appear in the cycle after the retire, then hold valid for exactly one cycle. Lanes without wr_en give valid=0.
- amt_o is combinational: registered entries overlaid with this cycle's retire writes (same priority as the retire write).
  - Effect: a rollback asserted in the same cycle as older retires restores a map that includes them.
- rollback_i:
  - AMT contents are never squashed.
  - Retires presented in the rollback cycle are still committed and still released.
  - No other effect on this block.
- Reset asserted mid-retire: the write and the pending release are both discarded; the post-reset state wins.
- Back-to-back retires to the same arch_reg across cycles chain correctly: cycle N+1 reads the value written at the end of N.
- No stall path. The ROB must not present wr_en with an X arch_reg; the bench asserts this.

Decomposition:
- Shared package (alongside CDB, DP_MT_*, MT_DP, AMT_ENTRY): typedefs ROB_AMT and AMT_FL; macros `RT_NUM and `ARCH_IDX_WIDTH. AMT_ENTRY is reused unchanged.
- One sub-module, amt_bypass: combinational per-lane old-tag selection and same-cycle overlay logic, parameterised on C_RT_NUM.

Test Plan:
1. Reset, then idle → amt_o[i].amt_tag == i for all 32 entries; amt_fl_o all valid=0.
2. Cycle N: lane0 {wr_en=1, arch=5, tag=40}.
   - In N: amt_o[5] == 40 (bypass).
   - N+1: amt_fl_o[0] = {1, 5}, amt_o[5] == 40.
   - N+2: amt_fl_o[0].valid == 0.
3. Same cycle: lane0 {arch=7, tag=33}, lane1 {arch=7, tag=34}.
   - Registered amt[7] == 34.
   - Next cycle: amt_fl_o[0].tag == 7, amt_fl_o[1].tag == 33.
4. Lane0 {arch=3, tag=50} with rollback_i=1 in the same cycle → amt_o[3] == 50 during that cycle; amt[3] stays 50 afterwards; tag 3 is released next cycle.
5. Lane1 {wr_en=1, arch=0, tag=45} → amt_o[0] stays 0; next cycle amt_fl_o[1] = {1, 45}.
6. Retire arch=9 tag=41 at N, async rst_i pulse mid-cycle N+1 → amt_o[9] == 9 immediately; amt_fl_o valid=0.
